// File: rtl/md_sequencer.sv
// md_sequencer: HI/LO multiply/divide sequencer for the EX stage.
//
// Runs MULT (fixed-latency product held in a pipeline register), DIV (radix-2
// restoring, one step per cycle, followed by a sign-fixup cycle) and MTHI/MTLO.
// Owns the architectural HI/LO registers and serves MFHI/MFLO reads.
//
// Build option: define MD_RESULT_BYPASS_EN to forward the completing HI/LO value
// to a read that arrives in the completion cycle instead of stalling it.
//
// Ports:
//   clk, rst_n                pipeline clock, asynchronous active-low reset
//   md_req                    EX instruction valid and not flushed
//   md_func                   0 none, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 5-7 none
//   md_sign                   signed MULT/DIV
//   md_a, md_b                forwarded rs / rt operands
//   md_hi_rd, md_lo_rd        EX instruction reads HI / LO
//   md_cancel                 abort in-flight op, block accept this cycle
//   md_stall                  hold IF/ID/EX (combinational)
//   md_busy                   MUL or DIV op in flight
//   md_done                   one-cycle pulse in the cycle HI/LO show a MULT/DIV result
//   md_rdata                  HI or LO for the EX result mux (0 when no read)
//   hi_o, lo_o                architectural HI / LO
module md_sequencer #(
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_req,
  input  logic [2:0]  md_func,
  input  logic        md_sign,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_hi_rd,
  input  logic        md_lo_rd,
  input  logic        md_cancel,
  output logic        md_stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] md_rdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CntMax = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [2:0] FuncMult = 3'd1;
  localparam logic [2:0] FuncDiv  = 3'd2;
  localparam logic [2:0] FuncMthi = 3'd3;
  localparam logic [2:0] FuncMtlo = 3'd4;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDivFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [63:0]       prod_q, prod_d;
  logic [31:0]       rem_q, rem_d;     // partial remainder
  logic [31:0]       quo_q, quo_d;     // dividend shifts out, quotient shifts in
  logic [31:0]       dvsr_q, dvsr_d;   // |divisor|
  logic [31:0]       dvnd_q, dvnd_d;   // raw dividend, returned on divide by zero
  logic              negq_q, negq_d, negr_q, negr_d;
  logic              done_q, done_d;

  logic              md_op, rd_req, rd_stall, completing;
  logic [63:0]       ext_a, ext_b;
  logic [31:0]       abs_a, abs_b;
  logic [32:0]       rem_sh;
  logic              rem_ge;
  logic [31:0]       fix_hi, fix_lo, new_hi, new_lo;

  // Operand preparation for accept.
  assign ext_a = {{32{md_sign & md_a[31]}}, md_a};
  assign ext_b = {{32{md_sign & md_b[31]}}, md_b};
  assign abs_a = (md_sign && md_a[31]) ? -md_a : md_a;
  assign abs_b = (md_sign && md_b[31]) ? -md_b : md_b;

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  assign rem_sh = {rem_q, quo_q[31]};
  assign rem_ge = rem_sh >= {1'b0, dvsr_q};

  // Divide-by-zero bypasses the sign fixup entirely.
  assign fix_lo = (dvsr_q == '0) ? '1     : (negq_q ? -quo_q : quo_q);
  assign fix_hi = (dvsr_q == '0) ? dvnd_q : (negr_q ? -rem_q : rem_q);

  assign new_hi = (state_q == StMul) ? prod_q[63:32] : fix_hi;
  assign new_lo = (state_q == StMul) ? prod_q[31:0]  : fix_lo;

  assign completing = ((state_q == StMul && cnt_q == '0) || state_q == StDivFix) && !md_cancel;

  assign md_busy = (state_q != StIdle);
  assign md_op   = (md_func == FuncMult) || (md_func == FuncDiv) ||
                   (md_func == FuncMthi) || (md_func == FuncMtlo);
  assign rd_req  = md_hi_rd | md_lo_rd;

`ifdef MD_RESULT_BYPASS_EN
  assign rd_stall = rd_req & ~completing;
`else
  assign rd_stall = rd_req;
`endif

  assign md_stall = md_busy & md_req & (md_op | rd_stall);

  always_comb begin
    md_rdata = '0;
    if (md_hi_rd) begin
      md_rdata = hi_q;
`ifdef MD_RESULT_BYPASS_EN
      if (completing) md_rdata = new_hi;
`endif
    end else if (md_lo_rd) begin
      md_rdata = lo_q;
`ifdef MD_RESULT_BYPASS_EN
      if (completing) md_rdata = new_lo;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (md_req && !md_stall && !md_cancel) begin
          unique case (md_func)
            FuncMult: begin
              prod_d  = ext_a * ext_b;
              cnt_d   = CntW'(MUL_LAT - 1);
              state_d = StMul;
            end
            FuncDiv: begin
              quo_d   = abs_a;
              rem_d   = '0;
              dvsr_d  = abs_b;
              dvnd_d  = md_a;
              negq_d  = md_sign & (md_a[31] ^ md_b[31]);
              negr_d  = md_sign & md_a[31];
              cnt_d   = CntW'(DIV_ITERS - 1);
              state_d = StDiv;
            end
            FuncMthi: hi_d = md_a;
            FuncMtlo: lo_d = md_a;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (md_cancel || cnt_q == '0) state_d = StIdle;
        else                          cnt_d   = cnt_q - CntW'(1);
      end
      StDiv: begin
        if (md_cancel) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_ge ? (rem_sh[31:0] - dvsr_q) : rem_sh[31:0];
          quo_d = {quo_q[30:0], rem_ge};
          if (cnt_q == '0) state_d = StDivFix;
          else             cnt_d   = cnt_q - CntW'(1);
        end
      end
      StDivFix: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Cancel suppresses the write and the done pulse.
    if (completing) begin
      hi_d   = new_hi;
      lo_d   = new_lo;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
    end
  end

  assign md_done = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequences the HI/LO multiply/divide resource for the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/DIV/MTHI/MTLO requests decoded from EX_CTRL MDFunc/MDSign and runs the multi-cycle operation.
- Owns the HI/LO registers and serves MFHI/MFLO reads (MDHIWB/MDLOWB).
- Raises a stall toward the hazard logic when an MD op or HI/LO read arrives while the unit is busy.

Parameters:
MUL_LAT, 4, cycles from MULT accept to HI/LO update (min 1)
DIV_ITERS, 32, radix-2 restoring divide iterations (fixed at data width)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
md_req  in  1  EX-stage instruction valid and not flushed this cycle
md_func  in  3  0 none, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 5-7 treated as none
md_sign  in  1  1 = signed MULT/DIV
md_a  in  32  forwarded rs operand
md_b  in  32  forwarded rt operand
md_hi_rd  in  1  EX instruction reads HI (MFHI)
md_lo_rd  in  1  EX instruction reads LO (MFLO)
md_cancel  in  1  abort in-flight op (exception or interrupt taken)
md_stall  out  1  hold IF/ID/EX, bubble into MEM
md_busy  out  1  MUL or DIV op in flight
md_done  out  1  one-cycle pulse when HI/LO are written by MULT/DIV
md_rdata  out  32  HI or LO value for the EX result mux
hi_o  out  32  architectural HI
lo_o  out  32  architectural LO

Behaviour:
- Reset: state IDLE, cnt=0, HI=LO=0, md_busy=0, md_done=0, md_stall=0.
- md_rdata is 0 when neither read strobe is set.
- States:
  - IDLE: accepts a new op.
  - MUL: cnt counts MUL_LAT-1 down to 0.
  - DIV: cnt counts DIV_ITERS-1 down to 0.
  - DIV_FIX: one cycle for sign correction.
- Accept (IDLE, md_req, md_stall=0):
  - MULT: latch operands, go to MUL.
  - DIV: latch |a| and |b| when signed and record the signs, go to DIV.
  - MTHI/MTLO: write HI or LO at the clock edge. No busy, no done.
- MUL: the 64-bit product (signed or unsigned) is computed at accept and held in a pipeline register. When cnt=0, write HI = product[63:32] and LO = product[31:0], pulse md_done, return to IDLE. Total latency is MUL_LAT cycles after the accept edge.
- DIV: one restoring shift/subtract step per cycle on a 33-bit partial remainder. After DIV_ITERS steps go to DIV_FIX.
- DIV_FIX:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Write LO = quotient, HI = remainder, pulse md_done.
  - Total latency is DIV_ITERS+1 cycles.
- Divide by zero: result is deterministic. LO = 0xFFFFFFFF and HI = dividend (raw md_a). Sign fixup is bypassed.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- md_stall is 1 when md_busy=1 and md_req=1 and any of these holds:
  - md_func is MULT, DIV, MTHI or MTLO;
  - md_hi_rd=1;
  - md_lo_rd=1.
- md_stall is combinational. The stalled instruction re-presents identical inputs the next cycle.
- Non-MD instructions never stall.
- HI/LO reads when not busy return the current registers (HI when md_hi_rd, else LO).
- md_cancel:
  - Returns the unit to IDLE on the next edge with HI/LO unchanged and no md_done.
  - Overrides a completion in the same cycle.
  - Also blocks an accept in that cycle.
- md_req with md_cancel in IDLE: nothing is accepted.
- rst_n asserted mid-operation: immediate IDLE, HI=LO=0.

Optional Feature:
MD_RESULT_BYPASS_EN
- Defined: in the completion cycle (MUL with cnt=0, or DIV_FIX), a pending HI/LO read is not stalled. md_rdata forwards the value being written that cycle.
- Undefined: the read stalls through the completion cycle and is served from the registers one cycle later.

Test Plan:
- Unsigned MULT a=0xFFFFFFFF, b=2:
  - md_busy for MUL_LAT cycles;
  - then HI=0x00000001, LO=0xFFFFFFFE, one md_done pulse.
- Signed DIV a=-7 (0xFFFFFFF9), b=2:
  - after 33 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF;
  - same operands unsigned give LO=0x7FFFFFFC, HI=0x00000001.
- DIV with b=0, a=0x1234:
  - LO=0xFFFFFFFF, HI=0x00001234.
  - Signed 0x80000000/-1 gives LO=0x80000000, HI=0.
- MFLO issued on the cycle after a DIV accept:
  - md_stall=1 until completion;
  - md_rdata equals the new LO on the first unstalled cycle;
  - check stall duration under both MD_RESULT_BYPASS_EN settings.
- MULT followed by md_cancel at cycle 2:
  - state returns to IDLE, md_done never pulses, HI/LO keep their prior values;
  - MTHI 0xA5A5A5A5 accepted in IDLE updates hi_o at the next edge.
- Assert rst_n low mid-DIV:
  - md_busy drops, HI=LO=0;
  - a new MULT after release completes normally.
